// File: rtl/regfile_bank_pkg.sv
// Shared definitions for the regfile_bank register file: clear-FSM state encoding and the
// byte-merge helper used by both the array write path and the read bypass path.
package regfile_bank_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } clr_state_e;

    // Port 1 is applied last, so it wins any byte both ports enable.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_b,
        input logic [7:0] b0,
        input logic       en0,
        input logic [7:0] b1,
        input logic       en1
    );
        logic [7:0] res;
        res = old_b;
        if (en0) res = b0;
        if (en1) res = b1;
        return res;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: address decode, zero-register/range masking and optional
// forwarding of same-cycle writes.
module regfile_rdport
    import regfile_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  ena_i,
    input  logic [AW-1:0]         raddr_i,
    input  logic [DATA_W-1:0]     mem_i [DEPTH],
    input  logic                  wr0_i,
    input  logic [AW-1:0]         waddr0_i,
    input  logic [DATA_W-1:0]     wdata0_i,
    input  logic [DATA_W/8-1:0]   wbe0_i,
    input  logic                  wr1_i,
    input  logic [AW-1:0]         waddr1_i,
    input  logic [DATA_W/8-1:0]   wbe1_i,
    input  logic [DATA_W-1:0]     wdata1_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic              hit;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;

    assign hit    = (32'(raddr_i) < DEPTH) && !((ZERO_REG != 0) && (raddr_i == '0));
    assign stored = mem_i[raddr_i];

    always_comb begin
        merged = stored;
        for (int k = 0; k < BE_W; k++) begin
            merged[8*k +: 8] = merge_byte(stored[8*k +: 8],
                                          wdata0_i[8*k +: 8],
                                          wr0_i && (waddr0_i == raddr_i) && wbe0_i[k],
                                          wdata1_i[8*k +: 8],
                                          wr1_i && (waddr1_i == raddr_i) && wbe1_i[k]);
        end
    end

    always_comb begin
        rdata_o = '0;
        if (ena_i && hit) begin
            rdata_o = (BYPASS != 0) ? merged : stored;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Dual-write, multi-read register file with byte enables, optional read forwarding and a
// sequential clear engine that sweeps one entry per enabled cycle.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1,
    localparam int unsigned BE_W    = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [AW-1:0]            waddr0,
    input  logic [AW-1:0]            waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [BE_W-1:0]          wbe0,
    input  logic [BE_W-1:0]          wbe1,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done
);

    clr_state_e        state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr0, wr1;

    function automatic logic addr_writable(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign busy     = (state_q == StSweep);
    assign clr_done = (state_q == StDone);

    // Reset qualifies the strobes so a write coincident with reset is never forwarded either.
    assign wr0 = rst_n && ena && we0 && !busy && addr_writable(waddr0);
    assign wr1 = rst_n && ena && we1 && !busy && addr_writable(waddr1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ena && clr_req) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                if (ena) begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < BE_W; k++) begin
                mem_d[e][8*k +: 8] = merge_byte(mem_q[e][8*k +: 8],
                                                wdata0[8*k +: 8],
                                                wr0 && (waddr0 == AW'(e)) && wbe0[k],
                                                wdata1[8*k +: 8],
                                                wr1 && (waddr1 == AW'(e)) && wbe1[k]);
            end
        end
        if (busy && ena) begin
            mem_d[cnt_q] = '0;
        end
        if (!rst_n) begin
            mem_d = '{default: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        mem_q <= mem_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .ena_i    (ena),
            .raddr_i  (raddr[i*AW +: AW]),
            .mem_i    (mem_q),
            .wr0_i    (wr0),
            .waddr0_i (waddr0),
            .wdata0_i (wdata0),
            .wbe0_i   (wbe0),
            .wr1_i    (wr1),
            .waddr1_i (waddr1),
            .wbe1_i   (wbe1),
            .wdata1_i (wdata1),
            .rdata_o  (rdata[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: randomized traffic against an array-based reference
// model plus directed scenarios for merging, zero/range masking and the clear engine.
module tb_regfile_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 24;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]     waddr0 = '0, waddr1 = '0;
    logic [DW-1:0]     wdata0 = '0, wdata1 = '0;
    logic [3:0]        wbe0 = '0, wbe1 = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*DW-1:0] rdata, rdata_nb;
    logic              busy, clr_done, busy_nb, clr_done_nb;

    always #5 clk = ~clk;

    regfile_bank #(
        .DATA_W (DW), .DEPTH (DEPTH), .NUM_RD (NRD), .ZERO_REG (1), .BYPASS (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .ena (ena), .we0 (we0), .we1 (we1),
        .waddr0 (waddr0), .waddr1 (waddr1), .wdata0 (wdata0), .wdata1 (wdata1),
        .wbe0 (wbe0), .wbe1 (wbe1), .raddr (raddr), .rdata (rdata),
        .clr_req (clr_req), .busy (busy), .clr_done (clr_done)
    );

    regfile_bank #(
        .DATA_W (DW), .DEPTH (DEPTH), .NUM_RD (NRD), .ZERO_REG (1), .BYPASS (0)
    ) dut_nb (
        .clk (clk), .rst_n (rst_n), .ena (ena), .we0 (we0), .we1 (we1),
        .waddr0 (waddr0), .waddr1 (waddr1), .wdata0 (wdata0), .wdata1 (wdata1),
        .wbe0 (wbe0), .wbe1 (wbe1), .raddr (raddr), .rdata (rdata_nb),
        .clr_req (clr_req), .busy (busy_nb), .clr_done (clr_done_nb)
    );

    // Reference model: stored words, sweep position (-1 when idle) and expected done pulse.
    logic [DW-1:0] model [DEPTH];
    int            sweep_idx = -1;
    bit            done_exp = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    function automatic bit wq(logic we, logic [AW-1:0] a);
        return (ena === 1'b1) && (we === 1'b1) && (rst_n === 1'b1) && (sweep_idx < 0)
               && (int'(a) < DEPTH) && (a != 0);
    endfunction

    function automatic logic [DW-1:0] post_word(int a);
        logic [DW-1:0] w;
        w = model[a];
        for (int k = 0; k < 4; k++) begin
            if (wq(we0, waddr0) && int'(waddr0) == a && wbe0[k]) w[8*k +: 8] = wdata0[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (wq(we1, waddr1) && int'(waddr1) == a && wbe1[k]) w[8*k +: 8] = wdata1[8*k +: 8];
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_rd(int a, bit byp);
        if (ena !== 1'b1 || a >= DEPTH || a == 0) return '0;
        return byp ? post_word(a) : model[a];
    endfunction

    task automatic set_read(int a0, int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic tick();
        logic [DW-1:0] nx [DEPTH];
        bit nd;
        nd = 1'b0;
        for (int a = 0; a < DEPTH; a++) nx[a] = post_word(a);
        if (sweep_idx >= 0) begin
            if (ena === 1'b1) begin
                nx[sweep_idx] = '0;
                sweep_idx++;
                if (sweep_idx == DEPTH) begin
                    sweep_idx = -1;
                    nd = 1'b1;
                end
            end
        end else if (!done_exp && ena === 1'b1 && clr_req === 1'b1) begin
            sweep_idx = 0;
        end
        if (rst_n !== 1'b1) begin
            for (int a = 0; a < DEPTH; a++) nx[a] = '0;
            sweep_idx = -1;
            nd = 1'b0;
        end
        @(posedge clk);
        for (int a = 0; a < DEPTH; a++) model[a] = nx[a];
        done_exp = nd;
        #1;
    endtask

    task automatic fill();
        ena = 1'b1;
        for (int a = 1; a < DEPTH; a += 2) begin
            we0 = 1'b1; waddr0 = AW'(a); wdata0 = DW'(a); wbe0 = 4'hF;
            we1 = (a + 1 < DEPTH); waddr1 = AW'(a + 1); wdata1 = DW'(a + 1); wbe1 = 4'hF;
            tick();
        end
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; clr_req = 1'b1;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = '1; wbe0 = 4'hF;
        tick(); tick();
        rst_n = 1'b1; we0 = 1'b0; clr_req = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (clr_done !== 1'b0) $display("FAIL reset_done: got %b want 0", clr_done); else n_pass++;
        for (int a = 0; a < 32; a++) begin
            set_read(a, 31 - a); #1;
            n_checks++;
            if (rdata !== '0) $display("FAIL reset_read a=%0d: got %h want 0", a, rdata);
            else n_pass++;
        end
    endtask

    task automatic test_basic_write();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; wbe0 = 4'hF;
        tick();
        we0 = 1'b0; set_read(5, 0); #1;
        n_checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) $display("FAIL basic_r5: got %h want deadbeef", rdata[31:0]);
        else n_pass++;
        n_checks++;
        if (rdata[63:32] !== 32'h0) $display("FAIL basic_r0: got %h want 0", rdata[63:32]);
        else n_pass++;
    endtask

    task automatic test_merge();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11223344; wbe0 = 4'hF;
        tick();
        wdata0 = 32'hAAAAAAAA; wbe0 = 4'h3;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h55555555; wbe1 = 4'h6;
        set_read(7, 7); #1;
        n_checks++;
        if (rdata[31:0] !== 32'h115555AA) $display("FAIL merge_bypass: got %h want 115555aa", rdata[31:0]);
        else n_pass++;
        n_checks++;
        if (rdata_nb[31:0] !== 32'h11223344) $display("FAIL merge_nobypass: got %h want 11223344", rdata_nb[31:0]);
        else n_pass++;
        tick();
        we0 = 1'b0; we1 = 1'b0; #1;
        n_checks++;
        if (rdata[63:32] !== 32'h115555AA) $display("FAIL merge_stored: got %h want 115555aa", rdata[63:32]);
        else n_pass++;
        n_checks++;
        if (rdata_nb[63:32] !== 32'h115555AA) $display("FAIL merge_stored_nb: got %h want 115555aa", rdata_nb[63:32]);
        else n_pass++;
    endtask

    task automatic test_zero_range();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; wbe0 = 4'hF;
        we1 = 1'b1; waddr1 = 5'd30; wdata1 = 32'h12345678; wbe1 = 4'hF;
        set_read(0, 30); #1;
        n_checks++;
        if (rdata !== '0) $display("FAIL zero_range_bypass: got %h want 0", rdata); else n_pass++;
        tick();
        we0 = 1'b0; we1 = 1'b0; #1;
        n_checks++;
        if (rdata !== '0) $display("FAIL zero_range_after: got %h want 0", rdata); else n_pass++;
        set_read(6, 22); #1;
        n_checks++;
        if (rdata !== {exp_rd(22, 1), exp_rd(6, 1)})
            $display("FAIL zero_range_alias: got %h want %h", rdata, {exp_rd(22, 1), exp_rd(6, 1)});
        else n_pass++;
    endtask

    task automatic test_random();
        int a0, a1;
        for (int i = 0; i < 300; i++) begin
            ena = ($urandom_range(0, 7) != 0);
            we0 = 1'($urandom); we1 = 1'($urandom);
            waddr0 = AW'($urandom_range(0, 31));
            waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, 31));
            wdata0 = $urandom; wdata1 = $urandom;
            wbe0 = 4'($urandom); wbe1 = 4'($urandom);
            a0 = $urandom_range(0, 1) ? int'(waddr0) : $urandom_range(0, 31);
            a1 = $urandom_range(0, 1) ? int'(waddr1) : $urandom_range(0, 31);
            set_read(a0, a1); #1;
            n_checks++;
            if (rdata !== {exp_rd(a1, 1), exp_rd(a0, 1)})
                $display("FAIL rand_read i=%0d a=%0d/%0d: got %h want %h", i, a0, a1, rdata,
                         {exp_rd(a1, 1), exp_rd(a0, 1)});
            else n_pass++;
            n_checks++;
            if (rdata_nb !== {exp_rd(a1, 0), exp_rd(a0, 0)})
                $display("FAIL rand_read_nb i=%0d a=%0d/%0d: got %h want %h", i, a0, a1, rdata_nb,
                         {exp_rd(a1, 0), exp_rd(a0, 0)});
            else n_pass++;
            tick();
        end
        ena = 1'b1; we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        fill();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 10) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hBAD0BAD0; wbe0 = 4'hF; clr_req = 1'b1;
                set_read(3, 20); #1;
                n_checks++;
                if (rdata !== {32'd20, 32'd0})
                    $display("FAIL clear_midread: got %h want %h", rdata, {32'd20, 32'd0});
                else n_pass++;
            end
            n_checks++;
            if (clr_done !== 1'b0) $display("FAIL clear_early_done n=%0d: got 1 want 0", n);
            else n_pass++;
            tick();
            we0 = 1'b0; clr_req = 1'b0; n++;
        end
        n_checks++;
        if (n != DEPTH) $display("FAIL clear_busy_len: got %0d want %0d", n, DEPTH); else n_pass++;
        n_checks++;
        if (clr_done !== 1'b1) $display("FAIL clear_done_pulse: got %b want 1", clr_done); else n_pass++;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_checks++;
        if ({busy, clr_done} !== 2'b00) $display("FAIL clear_after: got %b want 00", {busy, clr_done});
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            set_read(a, a); #1;
            n_checks++;
            if (rdata !== '0) $display("FAIL clear_read a=%0d: got %h want 0", a, rdata); else n_pass++;
        end
    endtask

    task automatic test_ena_freeze();
        int n;
        fill();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            ena = !(n >= 10 && n < 13);
            if (n == 11) begin
                set_read(15, 15); #1;
                n_checks++;
                if (rdata !== '0) $display("FAIL freeze_ena_read: got %h want 0", rdata); else n_pass++;
            end
            if (n == 13) begin
                set_read(9, 10); #1;
                n_checks++;
                if (rdata !== {32'd10, 32'd0})
                    $display("FAIL freeze_counter: got %h want %h", rdata, {32'd10, 32'd0});
                else n_pass++;
            end
            tick();
            n++;
        end
        ena = 1'b1;
        n_checks++;
        if (n != DEPTH + 3) $display("FAIL freeze_busy_len: got %0d want %0d", n, DEPTH + 3); else n_pass++;
        n_checks++;
        if (clr_done !== 1'b1) $display("FAIL freeze_done: got %b want 1", clr_done); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 12) $display("FAIL rstmid_reach: got %0d want 12", n); else n_pass++;
        rst_n = 1'b0; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hCAFEF00D; wbe0 = 4'hF;
        tick();
        rst_n = 1'b1; we0 = 1'b0; #1;
        n_checks++;
        if ({busy, clr_done} !== 2'b00) $display("FAIL rstmid_state: got %b want 00", {busy, clr_done});
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            set_read(a, a); #1;
            n_checks++;
            if (rdata !== '0) $display("FAIL rstmid_read a=%0d: got %h want 0", a, rdata); else n_pass++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_checks++;
            if ({busy, clr_done} !== {sweep_idx >= 0, done_exp})
                $display("FAIL rstmid_idle i=%0d: got %b want 00", i, {busy, clr_done});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_merge();
        test_zero_range();
        test_random();
        test_clear();
        test_ena_freeze();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
